// File: rtl/exe_wb_collision_sc.sv
// exe_wb_collision_sc
//   Writeback merge for one issue lane that carries both a simple ALU and a
//   multi-cycle complex ALU. At most one result is written back per cycle.
//   When several results are ready together, the extras wait in a small FIFO.
//   Held entries always drain ahead of new arrivals, so writeback order is kept.
//
// Ports
//   clk            : clock, rising edge
//   reset          : asynchronous, active-low reset
//   recoverFlag_i  : flush; empties the FIFO and drops same-cycle inputs
//   wbPacket_S_i   : simple-ALU result (.valid qualifies)
//   wbPacket_C_i   : complex-ALU result (.valid qualifies)
//   bypassPacket_o : registered tag/data/valid for the forward-check network
//   rfWrEn_o       : register-file write enable (valid && destValid)
//   rfWrAddr_o     : register-file write address (phyDest)
//   rfWrData_o     : register-file write data (destData)
//   ctrlPacket_o   : registered packet for the active list
//   issueBlock_o   : asks the issue queue not to select a simple op next cycle
//   occupancy_o    : holding-FIFO entry count
//   overflow_o     : sticky flag, set when an entry had to be dropped

`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

package exe_wb_collision_pkg;
  localparam int SIZE_PHYSICAL_LOG   = `SIZE_PHYSICAL_LOG;
  localparam int SIZE_DATA           = `SIZE_DATA;
  localparam int SIZE_ACTIVELIST_LOG = 5;
  localparam int SIZE_FLAGS          = 4;

  typedef struct packed {
    logic                           valid;
    logic [SIZE_ACTIVELIST_LOG-1:0] alID;
    logic [SIZE_FLAGS-1:0]          flags;
    logic                           destValid;
    logic [SIZE_PHYSICAL_LOG-1:0]   phyDest;
    logic [SIZE_DATA-1:0]           destData;
  } wbPkt;

  typedef struct packed {
    logic                         valid;
    logic [SIZE_PHYSICAL_LOG-1:0] tag;
    logic [SIZE_DATA-1:0]         data;
  } bypassPkt;
endpackage

module exe_wb_collision_sc
  import exe_wb_collision_pkg::*;
#(
  parameter int HOLD_DEPTH = 2,
  parameter int CNT_W      = $clog2(HOLD_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          recoverFlag_i,
  input  wbPkt                          wbPacket_S_i,
  input  wbPkt                          wbPacket_C_i,
  output bypassPkt                      bypassPacket_o,
  output logic                          rfWrEn_o,
  output logic [`SIZE_PHYSICAL_LOG-1:0] rfWrAddr_o,
  output logic [`SIZE_DATA-1:0]         rfWrData_o,
  output wbPkt                          ctrlPacket_o,
  output logic                          issueBlock_o,
  output logic [CNT_W-1:0]              occupancy_o,
  output logic                          overflow_o
);

  localparam int PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;

  wbPkt                         r_mem [HOLD_DEPTH];
  logic [PTR_W-1:0]             r_rd_ptr;
  logic [PTR_W-1:0]             r_wr_ptr;
  logic [CNT_W-1:0]             r_occ;
  bypassPkt                     r_bypass;
  logic                         r_rf_wr_en;
  logic [SIZE_PHYSICAL_LOG-1:0] r_rf_wr_addr;
  logic [SIZE_DATA-1:0]         r_rf_wr_data;
  wbPkt                         r_ctrl;
  logic                         r_issue_block;
  logic                         r_overflow;

  wbPkt             w_sel;
  logic             w_deq;
  logic             w_enq_c;
  logic             w_enq_s;
  logic             w_wr_c;
  logic             w_wr_s;
  logic             w_drop;
  logic [PTR_W-1:0] w_s_addr;
  logic [CNT_W-1:0] w_occ_next;
  logic             w_issue_block_next;

  // Selection priority: FIFO head, then C, then S. Whatever valid input is
  // not selected goes into the FIFO, C ahead of S.
  always_comb begin
    int room;
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned; that is what keeps latches from being inferred.
    w_sel   = '0;
    w_deq   = (r_occ != '0);
    w_enq_c = wbPacket_C_i.valid;
    w_enq_s = wbPacket_S_i.valid;

    if (w_deq) begin
      w_sel = r_mem[r_rd_ptr];
    end else if (wbPacket_C_i.valid) begin
      w_sel   = wbPacket_C_i;
      w_enq_c = 1'b0;
    end else if (wbPacket_S_i.valid) begin
      w_sel   = wbPacket_S_i;
      w_enq_s = 1'b0;
    end

    // A dequeue frees its slot in the same cycle. That means C always fits,
    // so only S can be dropped.
    room   = HOLD_DEPTH - int'(r_occ) + int'(w_deq);
    w_wr_c = w_enq_c && (room >= 1);
    w_wr_s = w_enq_s && (room >= (w_wr_c ? 2 : 1));
    w_drop = (w_enq_c && !w_wr_c) || (w_enq_s && !w_wr_s);

    w_s_addr           = r_wr_ptr + PTR_W'(w_wr_c);
    w_occ_next         = r_occ + CNT_W'(w_wr_c) + CNT_W'(w_wr_s) - CNT_W'(w_deq);
    w_issue_block_next = (int'(w_occ_next) >= HOLD_DEPTH - 1);
  end

  // NOTE: the holding storage has no reset. Only pointers and the count
  // define which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (!recoverFlag_i) begin
      if (w_wr_c) r_mem[r_wr_ptr] <= wbPacket_C_i;
      if (w_wr_s) r_mem[w_s_addr] <= wbPacket_S_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values no matter what order the statements are in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_occ         <= '0;
      r_bypass      <= '0;
      r_rf_wr_en    <= 1'b0;
      r_rf_wr_addr  <= '0;
      r_rf_wr_data  <= '0;
      r_ctrl        <= '0;
      r_issue_block <= 1'b0;
      r_overflow    <= 1'b0;
    end else if (recoverFlag_i) begin
      // Flush: drop held and arriving results. The error flag is kept.
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_occ         <= '0;
      r_bypass      <= '0;
      r_rf_wr_en    <= 1'b0;
      r_rf_wr_addr  <= '0;
      r_rf_wr_data  <= '0;
      r_ctrl        <= '0;
      r_issue_block <= 1'b0;
    end else begin
      r_rd_ptr      <= r_rd_ptr + PTR_W'(w_deq);
      r_wr_ptr      <= w_s_addr + PTR_W'(w_wr_s);
      r_occ         <= w_occ_next;
      // w_sel is all-zero when nothing is selected, which zeroes the data fields.
      r_bypass      <= '{valid: w_sel.valid, tag: w_sel.phyDest, data: w_sel.destData};
      r_rf_wr_en    <= w_sel.valid & w_sel.destValid;
      r_rf_wr_addr  <= w_sel.phyDest;
      r_rf_wr_data  <= w_sel.destData;
      r_ctrl        <= w_sel;
      r_issue_block <= w_issue_block_next;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign bypassPacket_o = r_bypass;
  assign rfWrEn_o       = r_rf_wr_en;
  assign rfWrAddr_o     = r_rf_wr_addr;
  assign rfWrData_o     = r_rf_wr_data;
  assign ctrlPacket_o   = r_ctrl;
  assign issueBlock_o   = r_issue_block;
  assign occupancy_o    = r_occ;
  assign overflow_o     = r_overflow;

endmodule

// File: tb/tb_exe_wb_collision_sc.sv
// Testbench for exe_wb_collision_sc. Each writeback the bench expects goes
// into a queue when the stimulus is driven. A monitor pops and compares one
// entry for every valid output cycle. Cycle-exact status outputs are checked
// inline in each scenario task.
`timescale 1ns/1ps
module tb_exe_wb_collision_sc;
  import exe_wb_collision_pkg::*;

  localparam int HOLD_DEPTH = 2;
  localparam int CNT_W      = $clog2(HOLD_DEPTH + 1);

  logic                         clk = 1'b0;
  logic                         reset = 1'b0;
  logic                         recoverFlag_i = 1'b0;
  wbPkt                         wbPacket_S_i = '0;
  wbPkt                         wbPacket_C_i = '0;
  bypassPkt                     bypassPacket_o;
  logic                         rfWrEn_o;
  logic [SIZE_PHYSICAL_LOG-1:0] rfWrAddr_o;
  logic [SIZE_DATA-1:0]         rfWrData_o;
  wbPkt                         ctrlPacket_o;
  logic                         issueBlock_o;
  logic [CNT_W-1:0]             occupancy_o;
  logic                         overflow_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  wbPkt sb[$];

  exe_wb_collision_sc #(.HOLD_DEPTH(HOLD_DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .recoverFlag_i  (recoverFlag_i),
    .wbPacket_S_i   (wbPacket_S_i),
    .wbPacket_C_i   (wbPacket_C_i),
    .bypassPacket_o (bypassPacket_o),
    .rfWrEn_o       (rfWrEn_o),
    .rfWrAddr_o     (rfWrAddr_o),
    .rfWrData_o     (rfWrData_o),
    .ctrlPacket_o   (ctrlPacket_o),
    .issueBlock_o   (issueBlock_o),
    .occupancy_o    (occupancy_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk = ~clk;

  function automatic wbPkt mk(input int dest, input int data, input bit dv = 1'b1);
    wbPkt p;
    p           = '0;
    p.valid     = 1'b1;
    p.alID      = dest[SIZE_ACTIVELIST_LOG-1:0];
    p.flags     = data[SIZE_FLAGS-1:0];
    p.destValid = dv;
    p.phyDest   = dest[SIZE_PHYSICAL_LOG-1:0];
    p.destData  = data[SIZE_DATA-1:0];
    return p;
  endfunction

  // Scoreboard monitor: every output-valid cycle must match the oldest expectation.
  always @(posedge clk) begin
    wbPkt     exp_p;
    bypassPkt exp_b;
    #1;
    if (bypassPacket_o.valid || ctrlPacket_o.valid || rfWrEn_o) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_wb got tag=%0h data=%0h exp none", bypassPacket_o.tag, bypassPacket_o.data);
      end else begin
        exp_p = sb.pop_front();
        exp_b = '{valid: 1'b1, tag: exp_p.phyDest, data: exp_p.destData};
        if (ctrlPacket_o !== exp_p || bypassPacket_o !== exp_b || rfWrEn_o !== exp_p.destValid ||
            rfWrAddr_o !== exp_p.phyDest || rfWrData_o !== exp_p.destData) begin
          n_fail++;
          $display("FAIL wb_order got tag=%0h data=%0h we=%0b exp tag=%0h data=%0h we=%0b",
                   bypassPacket_o.tag, bypassPacket_o.data, rfWrEn_o,
                   exp_p.phyDest, exp_p.destData, exp_p.destValid);
        end
      end
    end
  end

  // Apply one cycle of inputs, then return #1 after the capturing edge.
  task automatic drive(input wbPkt c, input wbPkt s, input logic rec = 1'b0);
    wbPacket_C_i  = c;
    wbPacket_S_i  = s;
    recoverFlag_i = rec;
    @(posedge clk);
    #1;
    wbPacket_C_i  = '0;
    wbPacket_S_i  = '0;
    recoverFlag_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({bypassPacket_o, ctrlPacket_o, rfWrEn_o, rfWrAddr_o, rfWrData_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %0h exp 0", {bypassPacket_o, ctrlPacket_o});
    end
    n_tests++;
    if ({occupancy_o, issueBlock_o, overflow_o} !== '0) begin
      n_fail++; $display("FAIL reset_status got %0b exp 0", {occupancy_o, issueBlock_o, overflow_o});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    sb.push_back(mk(5, 'h1234));
    drive('0, mk(5, 'h1234));
    n_tests++;
    if (bypassPacket_o.tag !== 7'd5 || bypassPacket_o.valid !== 1'b1 || rfWrEn_o !== 1'b1) begin
      n_fail++; $display("FAIL single_latency got tag=%0h v=%0b we=%0b exp 5 1 1", bypassPacket_o.tag, bypassPacket_o.valid, rfWrEn_o);
    end
    n_tests++;
    if (occupancy_o !== 0 || issueBlock_o !== 1'b0) begin
      n_fail++; $display("FAIL single_occ got occ=%0d blk=%0b exp 0 0", occupancy_o, issueBlock_o);
    end
    // destValid=0: still a bypass/ctrl writeback, but no register-file write.
    sb.push_back(mk(9, 'h55, 1'b0));
    drive('0, mk(9, 'h55, 1'b0));
    n_tests++;
    if (rfWrEn_o !== 1'b0 || bypassPacket_o.valid !== 1'b1) begin
      n_fail++; $display("FAIL no_dest got we=%0b v=%0b exp 0 1", rfWrEn_o, bypassPacket_o.valid);
    end
    drive('0, '0);
    n_tests++;
    if (bypassPacket_o !== '0 || ctrlPacket_o !== '0 || rfWrData_o !== '0) begin
      n_fail++; $display("FAIL idle_zero got %0h exp 0", bypassPacket_o);
    end
  endtask

  task automatic test_collision();
    sb.push_back(mk(7, 'h70));
    sb.push_back(mk(3, 'h30));
    drive(mk(7, 'h70), mk(3, 'h30));
    n_tests++;
    if (bypassPacket_o.tag !== 7'd7 || occupancy_o !== 1 || issueBlock_o !== 1'b1) begin
      n_fail++; $display("FAIL coll_c1 got tag=%0h occ=%0d blk=%0b exp 7 1 1", bypassPacket_o.tag, occupancy_o, issueBlock_o);
    end
    drive('0, '0);
    n_tests++;
    if (bypassPacket_o.tag !== 7'd3 || occupancy_o !== 0 || issueBlock_o !== 1'b0) begin
      n_fail++; $display("FAIL coll_c2 got tag=%0h occ=%0d blk=%0b exp 3 0 0", bypassPacket_o.tag, occupancy_o, issueBlock_o);
    end
    drive('0, '0);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL coll_drain got %0d pending exp 0", sb.size());
    end
  endtask

  task automatic test_overflow();
    // a1 out; b1 held; a2,b2 held; a3 held, b3 dropped. Drain: b1 a2 b2 a3.
    sb.push_back(mk(16, 'hA1)); sb.push_back(mk(17, 'hB1));
    sb.push_back(mk(18, 'hA2)); sb.push_back(mk(19, 'hB2));
    sb.push_back(mk(20, 'hA3));
    drive(mk(16, 'hA1), mk(17, 'hB1));
    drive(mk(18, 'hA2), mk(19, 'hB2));
    n_tests++;
    if (occupancy_o !== 2 || overflow_o !== 1'b0) begin
      n_fail++; $display("FAIL ovf_pre got occ=%0d ovf=%0b exp 2 0", occupancy_o, overflow_o);
    end
    drive(mk(20, 'hA3), mk(21, 'hB3));
    n_tests++;
    if (occupancy_o !== 2 || overflow_o !== 1'b1 || issueBlock_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set got occ=%0d ovf=%0b blk=%0b exp 2 1 1", occupancy_o, overflow_o, issueBlock_o);
    end
    drive('0, '0);
    n_tests++;
    if (occupancy_o !== 1 || issueBlock_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drain1 got occ=%0d blk=%0b exp 1 1", occupancy_o, issueBlock_o);
    end
    repeat (2) drive('0, '0);
    n_tests++;
    if (occupancy_o !== 0 || issueBlock_o !== 1'b0 || overflow_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky got occ=%0d blk=%0b ovf=%0b exp 0 0 1", occupancy_o, issueBlock_o, overflow_o);
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL ovf_drain got %0d pending exp 0", sb.size());
    end
  endtask

  task automatic test_recover();
    sb.push_back(mk(32, 'h101)); sb.push_back(mk(33, 'h102));
    drive(mk(32, 'h101), mk(33, 'h102));
    drive(mk(34, 'h103), mk(35, 'h104));
    n_tests++;
    if (occupancy_o !== 2) begin
      n_fail++; $display("FAIL rec_fill got occ=%0d exp 2", occupancy_o);
    end
    drive(mk(36, 'h105), mk(37, 'h106), 1'b1);
    n_tests++;
    if (occupancy_o !== 0 || bypassPacket_o.valid !== 1'b0 || ctrlPacket_o.valid !== 1'b0 ||
        rfWrEn_o !== 1'b0 || issueBlock_o !== 1'b0) begin
      n_fail++; $display("FAIL rec_flush got occ=%0d v=%0b blk=%0b exp 0 0 0", occupancy_o, bypassPacket_o.valid, issueBlock_o);
    end
    n_tests++;
    if (overflow_o !== 1'b1) begin
      n_fail++; $display("FAIL rec_ovf_kept got %0b exp 1", overflow_o);
    end
    repeat (3) drive('0, '0);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL rec_drain got %0d pending exp 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    sb.push_back(mk(40, 'h201)); sb.push_back(mk(41, 'h202));
    sb.push_back(mk(42, 'h203)); sb.push_back(mk(43, 'h204));
    drive(mk(40, 'h201), mk(41, 'h202));
    drive(mk(42, 'h203), '0);
    n_tests++;
    if (bypassPacket_o.tag !== 7'd41 || occupancy_o !== 1) begin
      n_fail++; $display("FAIL b2b_held_first got tag=%0d occ=%0d exp 41 1", bypassPacket_o.tag, occupancy_o);
    end
    drive(mk(43, 'h204), '0);
    n_tests++;
    if (bypassPacket_o.tag !== 7'd42 || occupancy_o !== 1) begin
      n_fail++; $display("FAIL b2b_order got tag=%0d occ=%0d exp 42 1", bypassPacket_o.tag, occupancy_o);
    end
    repeat (2) drive('0, '0);
    n_tests++;
    if (sb.size() != 0 || occupancy_o !== 0) begin
      n_fail++; $display("FAIL b2b_drain got pend=%0d occ=%0d exp 0 0", sb.size(), occupancy_o);
    end
  endtask

  task automatic test_async_reset();
    sb.push_back(mk(50, 'h301));
    drive(mk(50, 'h301), mk(51, 'h302));
    n_tests++;
    if (occupancy_o !== 1) begin
      n_fail++; $display("FAIL ar_setup got occ=%0d exp 1", occupancy_o);
    end
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (bypassPacket_o !== '0 || ctrlPacket_o !== '0 || rfWrEn_o !== 1'b0 ||
        occupancy_o !== 0 || overflow_o !== 1'b0 || issueBlock_o !== 1'b0) begin
      n_fail++; $display("FAIL ar_immediate got v=%0b occ=%0d ovf=%0b exp 0 0 0", bypassPacket_o.valid, occupancy_o, overflow_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    sb.push_back(mk(60, 'h401));
    drive('0, mk(60, 'h401));
    n_tests++;
    if (bypassPacket_o.tag !== 7'd60 || bypassPacket_o.valid !== 1'b1 || occupancy_o !== 0) begin
      n_fail++; $display("FAIL ar_restart got tag=%0d v=%0b occ=%0d exp 60 1 0", bypassPacket_o.tag, bypassPacket_o.valid, occupancy_o);
    end
    repeat (2) drive('0, '0);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL ar_drain got %0d pending exp 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_collision();
    test_overflow();
    test_recover();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
